// File: rtl/icache_stage2.sv
// Second pipeline stage of the 4-way, 16-set, 32-byte-line instruction cache.
// Compares the registered request against the SRAM read-out, handles misses and per-set PLRU.
module icache_stage2 (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [31:0]  s1_addr_i,
    input  logic [3:0]   s1_rmask_i,
    input  logic         flush_i,
    input  logic [22:0]  tag_rdata_i   [4],
    input  logic         valid_rdata_i [4],
    input  logic [255:0] data_rdata_i  [4],
    input  logic         dfp_resp_i,
    output logic         ufp_resp_o,
    output logic [31:0]  ufp_rdata_o,
    output logic         stall_sig_o,
    output logic [1:0]   way_evict_o,
    output logic [31:0]  dfp_addr_o,
    output logic         dfp_read_o
);

    typedef enum logic [1:0] {StRun, StFetch, StRefill} state_e;

    state_e      state_q, state_d;
    logic [31:2] req_addr_q, req_addr_d;
    logic        req_valid_q, req_valid_d;
    logic        kill_q, kill_d;
    logic [1:0]  way_evict_q, way_evict_d;
    logic [2:0]  plru_q [16];

    logic        hit;
    logic [1:0]  hit_way;
    logic [1:0]  victim;
    logic [2:0]  plru_cur;
    logic [2:0]  plru_wdata;
    logic        plru_we;
    logic [3:0]  set_idx;

    // Byte-offset bits never select anything in a word-wide read.
    logic unused_addr_bits;
    assign unused_addr_bits = ^s1_addr_i[1:0];

    assign set_idx     = req_addr_q[8:5];
    assign plru_cur    = plru_q[set_idx];
    assign way_evict_o = way_evict_q;

    // Descending scan so the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (valid_rdata_i[w] && (tag_rdata_i[w] == req_addr_q[31:9])) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    always_comb begin
        if (!plru_cur[0]) begin
            victim = plru_cur[1] ? 2'd1 : 2'd0;
        end else begin
            victim = plru_cur[2] ? 2'd3 : 2'd2;
        end
        for (int w = 3; w >= 0; w--) begin
            if (!valid_rdata_i[w]) begin
                victim = 2'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        way_evict_d = way_evict_q;
        ufp_resp_o  = 1'b0;
        ufp_rdata_o = 32'd0;
        stall_sig_o = 1'b0;
        dfp_read_o  = 1'b0;
        dfp_addr_o  = 32'd0;
        plru_we     = 1'b0;
        plru_wdata  = plru_cur;
        unique case (state_q)
            StRun: begin
                if (req_valid_q && !flush_i) begin
                    if (hit) begin
                        ufp_resp_o  = 1'b1;
                        ufp_rdata_o = data_rdata_i[hit_way][{req_addr_q[4:2], 5'b0} +: 32];
                        plru_we     = 1'b1;
                        if (!hit_way[1]) begin
                            plru_wdata[0] = 1'b1;
                            plru_wdata[1] = (hit_way == 2'd0);
                        end else begin
                            plru_wdata[0] = 1'b0;
                            plru_wdata[2] = (hit_way == 2'd2);
                        end
                    end else begin
                        stall_sig_o = 1'b1;
                        way_evict_d = victim;
                        state_d     = StFetch;
                    end
                end
            end
            StFetch: begin
                dfp_read_o  = 1'b1;
                dfp_addr_o  = {req_addr_q[31:5], 5'b0};
                stall_sig_o = 1'b1;
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (dfp_resp_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                stall_sig_o = 1'b1;
                kill_d      = 1'b0;
                state_d     = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // A fetch in flight keeps its request valid; the kill takes effect as the refill retires.
    always_comb begin
        req_addr_d  = req_addr_q;
        req_valid_d = req_valid_q;
        if (!stall_sig_o) begin
            req_addr_d  = s1_addr_i[31:2];
            req_valid_d = |s1_rmask_i;
        end
        if ((state_q == StRun) && flush_i) begin
            req_valid_d = 1'b0;
        end
        if ((state_q == StRefill) && (kill_q || flush_i)) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            req_addr_q  <= '0;
            req_valid_q <= 1'b0;
            kill_q      <= 1'b0;
            way_evict_q <= 2'd0;
            for (int s = 0; s < 16; s++) begin
                plru_q[s] <= 3'd0;
            end
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            kill_q      <= kill_d;
            way_evict_q <= way_evict_d;
            if (plru_we) begin
                plru_q[set_idx] <= plru_wdata;
            end
        end
    end

endmodule
